// File: rtl/max7219_rx_pkg.sv
// Shared definitions for the MAX7219 serial link: register addresses and frame
// field extraction, common to the transmitting FSM and this receiver.
package max7219_rx_pkg;

   localparam logic [3:0] ADDR_NOOP      = 4'h0;
   localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
   localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
   localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
   localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
   localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
   localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
   localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
   localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
   localparam logic [3:0] ADDR_DECODE    = 4'h9;
   localparam logic [3:0] ADDR_INTENSITY = 4'hA;
   localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
   localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
   localparam logic [3:0] ADDR_TEST      = 4'hF;

   // Only the low 12 bits of a frame carry address and data; anything shifted
   // in above them can never influence a commit.
   localparam int FRAME_WIN = 12;

   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } frame_t;

   function automatic frame_t split_frame(input logic [FRAME_WIN-1:0] word);
      frame_t f;
      f.addr = word[11:8];
      f.data = word[7:0];
      return f;
   endfunction

endpackage

// File: rtl/max7219_rx_if.sv
// The three-wire MAX7219 serial link: the controller drives it, the display
// (or this receiver) listens.
interface max7219_rx_if;

   logic max_sck;
   logic max_load;
   logic max_din;

   modport master (output max_sck, output max_load, output max_din);
   modport slave  (input  max_sck, input  max_load, input  max_din);

endinterface

// File: rtl/max7219_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous line, with a registered level
// and a registered rising-edge strobe that stay aligned with each other.
module max7219_rx_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] chain;
   logic [SYNC_STAGES:0]   fill;

   // fill marks when chain and level hold real samples, so a line that is
   // already high at reset release never looks like a 0->1 edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         chain <= '0;
         fill  <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the previous
         // cycle's values, which is exactly what a shift chain needs.
         chain <= {chain[SYNC_STAGES-2:0], d};
         fill  <= {fill[SYNC_STAGES-1:0], 1'b1};
         level <= chain[SYNC_STAGES-1];
         rise  <= fill[SYNC_STAGES] & chain[SYNC_STAGES-1] & ~level;
      end
   end

endmodule

// File: rtl/max7219_rx.sv
// MAX7219-compatible serial receiver: shifts frames on SCK, commits on LOAD
// and decodes them into the digit and control register file.
module max7219_rx
   import max7219_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = 16,
   parameter int NUM_DIGITS  = 8
) (
   input  logic               clock,
   input  logic               reset,
   max7219_rx_if.slave        link,
   input  logic [2:0]         rd_digit,
   output logic [7:0]         rd_data,
   output logic [7:0]         decode_mode,
   output logic [3:0]         intensity,
   output logic [2:0]         scan_limit,
   output logic               shutdown_n,
   output logic               display_test,
   output logic               frame_valid,
   output logic [3:0]         frame_addr,
   output logic [7:0]         frame_data,
   output logic               frame_short
);

   localparam int DIG_W = $clog2(NUM_DIGITS);

   logic sck_rise, load_rise, din_s;

   max7219_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
      .clock(clock), .reset(reset), .d(link.max_sck),  .level(),      .rise(sck_rise)
   );
   max7219_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load (
      .clock(clock), .reset(reset), .d(link.max_load), .level(),      .rise(load_rise)
   );
   max7219_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_din (
      .clock(clock), .reset(reset), .d(link.max_din),  .level(din_s), .rise()
   );

   logic [FRAME_WIN-1:0] sr, sr_next;
   logic [4:0]           bit_cnt, cnt_next;
   logic [7:0]           digit [NUM_DIGITS];
   logic                 frame_full;
   logic                 is_digit;
   logic [DIG_W-1:0]     dig_sel;
   frame_t               cur;

   // The shift is resolved first so a LOAD edge in the same cycle sees the
   // bit that arrived with it, both in the data and in the bit count.
   always_comb begin
      // NOTE: every signal gets a default before any branch, otherwise a
      // path that leaves it unassigned infers a latch.
      sr_next  = sr;
      cnt_next = bit_cnt;
      if (sck_rise) begin
         sr_next = {sr[FRAME_WIN-2:0], din_s};
         if (bit_cnt != 5'd31) cnt_next = bit_cnt + 5'd1;
      end
      frame_full = int'(cnt_next) >= FRAME_BITS;
      cur        = split_frame(sr_next);
      is_digit   = (cur.addr >= ADDR_DIGIT0) &&
                   (int'(cur.addr) < int'(ADDR_DIGIT0) + NUM_DIGITS);
      dig_sel    = DIG_W'(cur.addr - ADDR_DIGIT0);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sr           <= '0;
         bit_cnt      <= '0;
         // NOTE: the digit array is small and must read back as zero after
         // reset, so it is cleared here rather than left as uninitialised RAM.
         for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
         rd_data      <= '0;
         decode_mode  <= '0;
         intensity    <= '0;
         scan_limit   <= '0;
         shutdown_n   <= 1'b0;
         display_test <= 1'b0;
         frame_valid  <= 1'b0;
         frame_addr   <= '0;
         frame_data   <= '0;
         frame_short  <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_short <= 1'b0;
         sr          <= sr_next;
         bit_cnt     <= cnt_next;
         rd_data     <= digit[rd_digit];

         if (load_rise) begin
            bit_cnt <= '0;
            if (frame_full) begin
               frame_valid <= 1'b1;
               frame_addr  <= cur.addr;
               frame_data  <= cur.data;
               if (is_digit) begin
                  digit[dig_sel] <= cur.data;
               end else begin
                  case (cur.addr)
                     ADDR_DECODE:    decode_mode  <= cur.data;
                     ADDR_INTENSITY: intensity    <= cur.data[3:0];
                     ADDR_SCANLIM:   scan_limit   <= cur.data[2:0];
                     ADDR_SHUTDOWN:  shutdown_n   <= cur.data[0];
                     ADDR_TEST:      display_test <= cur.data[0];
                     ADDR_NOOP:      ;
                     default:        ;
                  endcase
               end
            end else begin
               frame_short <= 1'b1;
            end
         end
      end
   end

endmodule
